// File: rtl/ctrl_pkg.sv
// Definitions shared by the fetch unit and the control unit: opcodes,
// special ops, fetch-state encoding and the constant jump-target table.
package ctrl_pkg;

  localparam int OPC_W      = 4;
  localparam int SPC_W      = 3;
  localparam int INSTR_W    = 9;
  localparam int JLUT_IDX_W = 5;
  localparam int JLUT_W     = 16;
  localparam int JLUT_SLOTS = 1 << JLUT_IDX_W;

  localparam logic [OPC_W-1:0] OP_NOP     = 4'h0;
  localparam logic [OPC_W-1:0] OP_LOAD    = 4'h1;
  localparam logic [OPC_W-1:0] OP_STORE   = 4'h2;
  localparam logic [OPC_W-1:0] OP_ADD     = 4'h3;
  localparam logic [OPC_W-1:0] OP_SUB     = 4'h4;
  localparam logic [OPC_W-1:0] OP_AND     = 4'h5;
  localparam logic [OPC_W-1:0] OP_OR      = 4'h6;
  localparam logic [OPC_W-1:0] OP_XOR     = 4'h7;
  localparam logic [OPC_W-1:0] OP_SHIFT   = 4'h8;
  localparam logic [OPC_W-1:0] OP_CMP     = 4'h9;
  localparam logic [OPC_W-1:0] OP_BRANCH  = 4'hA;
  localparam logic [OPC_W-1:0] OP_JMP     = 4'hB;
  localparam logic [OPC_W-1:0] OP_SPECIAL = 4'hF;

  localparam logic [SPC_W-1:0] SP_NOP   = 3'd0;
  localparam logic [SPC_W-1:0] SP_CLRF  = 3'd1;
  localparam logic [SPC_W-1:0] SP_SETF  = 3'd2;
  localparam logic [SPC_W-1:0] SP_HALT  = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_e;

  // Jump targets; unlisted slots point at a 16-word stride so stray jumps are recognisable.
  function automatic logic [JLUT_W-1:0] jlut_init(input logic [JLUT_IDX_W-1:0] idx);
    logic [JLUT_W-1:0] tgt;
    case (idx)
      5'd0:    tgt = 16'h0000;
      5'd1:    tgt = 16'h0010;
      5'd2:    tgt = 16'h0020;
      5'd3:    tgt = 16'h0040;
      5'd4:    tgt = 16'h0100;
      5'd5:    tgt = 16'h0080;
      5'd6:    tgt = 16'h00C0;
      5'd7:    tgt = 16'h0200;
      5'd8:    tgt = 16'h03F0;
      default: tgt = {7'd0, idx, 4'd0};
    endcase
    return tgt;
  endfunction

endpackage

// File: rtl/jump_lut.sv
// Combinational jump-target lookup; slots at or beyond DEPTH read as zero.
module jump_lut
  import ctrl_pkg::*;
#(
  parameter int PC_W  = 10,
  parameter int DEPTH = 32
) (
  input  logic [JLUT_IDX_W-1:0] index_i,
  output logic [PC_W-1:0]       target_o
);

  logic [JLUT_W-1:0] entry [JLUT_SLOTS];

  for (genvar gi = 0; gi < JLUT_SLOTS; gi++) begin : g_entry
    if (gi < DEPTH) begin : g_used
      assign entry[gi] = jlut_init(JLUT_IDX_W'(gi));
    end else begin : g_unused
      assign entry[gi] = '0;
    end
  end

  assign target_o = PC_W'(entry[index_i]);

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction-fetch front end: program counter, redirect handling,
// run/halt sequencing and retired-instruction counting.
module instr_fetch_unit
  import ctrl_pkg::*;
#(
  parameter int PC_W       = 10,
  parameter int CNT_W      = 16,
  parameter int JLUT_DEPTH = 32
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic                  start_i,
  output logic [PC_W-1:0]       imem_addr_o,
  input  logic [INSTR_W-1:0]    imem_data_i,
  output logic [INSTR_W-1:0]    instruction_o,
  output logic                  instr_valid_o,
  output logic [PC_W-1:0]       issued_pc_o,
  input  logic                  branch_i,
  input  logic                  cond_true_i,
  input  logic [4:0]            branch_offset_i,
  input  logic                  jmp_ctrl_i,
  input  logic [JLUT_IDX_W-1:0] jmp_index_i,
  input  logic                  done_ctrl_i,
  output logic                  halted_o,
  output logic [CNT_W-1:0]      retired_o
);

  fetch_state_e         state_q, state_d;
  logic [PC_W-1:0]      pc_q, pc_d;
  logic [INSTR_W-1:0]   instr_q, instr_d;
  logic                 valid_q, valid_d;
  logic [PC_W-1:0]      issued_pc_q, issued_pc_d;
  logic                 halted_q, halted_d;
  logic [CNT_W-1:0]     retired_q, retired_d;

  logic [PC_W-1:0]      jump_target;
  logic [PC_W-1:0]      offset_ext;
  logic [PC_W-1:0]      branch_target;
  logic                 take_jump;
  logic                 take_branch;

  jump_lut #(
    .PC_W  (PC_W),
    .DEPTH (JLUT_DEPTH)
  ) u_jump_lut (
    .index_i  (jmp_index_i),
    .target_o (jump_target)
  );

  assign offset_ext    = PC_W'($signed(branch_offset_i));
  assign branch_target = issued_pc_q + offset_ext;

  // Redirects are only meaningful while a real instruction sits on the output.
  assign take_jump   = valid_q && jmp_ctrl_i;
  assign take_branch = valid_q && branch_i && cond_true_i;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    valid_d     = valid_q;
    issued_pc_d = issued_pc_q;
    halted_d    = halted_q;
    retired_d   = retired_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          pc_d    = '0;
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        if (valid_q && done_ctrl_i) begin
          state_d  = ST_HALT;
          valid_d  = 1'b0;
          halted_d = 1'b1;
        end else begin
          issued_pc_d = pc_q;
          if (take_jump || take_branch) begin
            pc_d    = take_jump ? jump_target : branch_target;
            instr_d = '0;
            valid_d = 1'b0;
          end else begin
            pc_d    = pc_q + PC_W'(1);
            instr_d = imem_data_i;
            valid_d = 1'b1;
            if (retired_q != '1) begin
              retired_d = retired_q + CNT_W'(1);
            end
          end
        end
      end

      ST_HALT: begin
        if (start_i) begin
          halted_d  = 1'b0;
          pc_d      = '0;
          retired_d = '0;
          state_d   = ST_RUN;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= ST_IDLE;
      pc_q        <= '0;
      instr_q     <= '0;
      valid_q     <= 1'b0;
      issued_pc_q <= '0;
      halted_q    <= 1'b0;
      retired_q   <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      valid_q     <= valid_d;
      issued_pc_q <= issued_pc_d;
      halted_q    <= halted_d;
      retired_q   <= retired_d;
    end
  end

  assign imem_addr_o   = pc_q;
  assign instruction_o = instr_q;
  assign instr_valid_o = valid_q;
  assign issued_pc_o   = issued_pc_q;
  assign halted_o      = halted_q;
  assign retired_o     = retired_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed scoreboard bench for instr_fetch_unit: a full-size instance for
// fetch/redirect/halt behaviour and a narrow instance for wrap and saturation.
module tb_instr_fetch_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, branch, cond_true, jmp, done;
  logic [4:0] boff, jidx;

  logic [9:0]  addr, ipc;
  logic [8:0]  rom, instr;
  logic        valid, halted;
  logic [15:0] ret;

  logic [3:0]  addr_s, ipc_s;
  logic [8:0]  rom_s, instr_s;
  logic        valid_s, halted_s;
  logic [1:0]  ret_s;

  assign rom   = addr[8:0];
  assign rom_s = {5'd0, addr_s};

  instr_fetch_unit dut (
    .clock_i         (clk),
    .reset_i         (rst),
    .start_i         (start),
    .imem_addr_o     (addr),
    .imem_data_i     (rom),
    .instruction_o   (instr),
    .instr_valid_o   (valid),
    .issued_pc_o     (ipc),
    .branch_i        (branch),
    .cond_true_i     (cond_true),
    .branch_offset_i (boff),
    .jmp_ctrl_i      (jmp),
    .jmp_index_i     (jidx),
    .done_ctrl_i     (done),
    .halted_o        (halted),
    .retired_o       (ret)
  );

  instr_fetch_unit #(.PC_W(4), .CNT_W(2)) dut_s (
    .clock_i         (clk),
    .reset_i         (rst),
    .start_i         (start),
    .imem_addr_o     (addr_s),
    .imem_data_i     (rom_s),
    .instruction_o   (instr_s),
    .instr_valid_o   (valid_s),
    .issued_pc_o     (ipc_s),
    .branch_i        (branch),
    .cond_true_i     (cond_true),
    .branch_offset_i (boff),
    .jmp_ctrl_i      (jmp),
    .jmp_index_i     (jidx),
    .done_ctrl_i     (done),
    .halted_o        (halted_s),
    .retired_o       (ret_s)
  );

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic        valid;
    logic [8:0]  instr;
    logic [9:0]  ipc;
    logic [15:0] ret;
    logic        halted;
    logic        chk_ipc;
  } exp_t;

  exp_t sb_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_cmp++;
    assert (obs === want) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, want);
    end
  endtask

  task automatic expect_edge(input logic v, input logic [8:0] i, input logic [9:0] p,
                             input logic [15:0] r, input logic h, input logic cp);
    exp_t e;
    e.valid = v; e.instr = i; e.ipc = p; e.ret = r; e.halted = h; e.chk_ipc = cp;
    sb_q.push_back(e);
  endtask

  task automatic cycle(input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    assert (sb_q.size() != 0) else begin
      n_err++;
      $error("FAIL %s.sb: observed empty scoreboard expected an entry", tag);
    end
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      chk($sformatf("%s.valid", tag), 32'(valid), 32'(e.valid));
      chk($sformatf("%s.instr", tag), 32'(instr), 32'(e.instr));
      chk($sformatf("%s.retired", tag), 32'(ret), 32'(e.ret));
      chk($sformatf("%s.halted", tag), 32'(halted), 32'(e.halted));
      if (e.chk_ipc) chk($sformatf("%s.issued_pc", tag), 32'(ipc), 32'(e.ipc));
    end
    $display("step %-16s addr=%03h valid=%0b instr=%03h issued_pc=%03h retired=%0d halted=%0b",
             tag, addr, valid, instr, ipc, ret, halted);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; branch = 1'b0; cond_true = 1'b0;
    jmp = 1'b0; done = 1'b0; boff = '0; jidx = '0;
    #1 rst = 1'b1;
    #2;
    chk("rst.valid", 32'(valid), 0);
    chk("rst.instr", 32'(instr), 0);
    chk("rst.issued_pc", 32'(ipc), 0);
    chk("rst.halted", 32'(halted), 0);
    chk("rst.retired", 32'(ret), 0);
    chk("rst.addr", 32'(addr), 0);
    chk("rst.small_retired", 32'(ret_s), 0);
    @(negedge clk);
    rst = 1'b0;

    // start and sequential fetch
    start = 1'b1;
    expect_edge(1'b0, 9'h000, 10'h000, 16'd0, 1'b0, 1'b1); cycle("start");
    start = 1'b0;
    chk("addr_after_start", 32'(addr), 0);
    expect_edge(1'b1, 9'h000, 10'h000, 16'd1, 1'b0, 1'b1); cycle("seq0");
    chk("addr_seq0", 32'(addr), 1);
    expect_edge(1'b1, 9'h001, 10'h001, 16'd2, 1'b0, 1'b1); cycle("seq1");
    chk("addr_seq1", 32'(addr), 2);
    expect_edge(1'b1, 9'h002, 10'h002, 16'd3, 1'b0, 1'b1); cycle("seq2");
    chk("addr_seq2", 32'(addr), 3);
    expect_edge(1'b1, 9'h003, 10'h003, 16'd4, 1'b0, 1'b1); cycle("seq3");
    expect_edge(1'b1, 9'h004, 10'h004, 16'd5, 1'b0, 1'b1); cycle("seq4");
    expect_edge(1'b1, 9'h005, 10'h005, 16'd6, 1'b0, 1'b1); cycle("seq5");

    // taken branch at issued_pc=5, offset -3
    branch = 1'b1; cond_true = 1'b1; boff = 5'b11101;
    expect_edge(1'b0, 9'h000, 10'h000, 16'd6, 1'b0, 1'b0); cycle("br_taken");
    branch = 1'b0; cond_true = 1'b0; boff = '0;
    chk("addr_br_taken", 32'(addr), 2);
    expect_edge(1'b1, 9'h002, 10'h002, 16'd7, 1'b0, 1'b1); cycle("br_target");

    // start while running is ignored
    start = 1'b1;
    expect_edge(1'b1, 9'h003, 10'h003, 16'd8, 1'b0, 1'b1); cycle("start_in_run");
    start = 1'b0;
    chk("addr_start_in_run", 32'(addr), 4);
    expect_edge(1'b1, 9'h004, 10'h004, 16'd9, 1'b0, 1'b1); cycle("seq_b4");
    expect_edge(1'b1, 9'h005, 10'h005, 16'd10, 1'b0, 1'b1); cycle("seq_b5");

    // branch not taken at issued_pc=5
    branch = 1'b1; cond_true = 1'b0; boff = 5'b11101;
    expect_edge(1'b1, 9'h006, 10'h006, 16'd11, 1'b0, 1'b1); cycle("br_not_taken");
    branch = 1'b0; boff = '0;
    chk("addr_br_not_taken", 32'(addr), 7);

    // jump beats a simultaneous taken branch
    jmp = 1'b1; jidx = 5'd4; branch = 1'b1; cond_true = 1'b1; boff = 5'b11101;
    expect_edge(1'b0, 9'h000, 10'h000, 16'd11, 1'b0, 1'b0); cycle("jump_wins");
    branch = 1'b0; cond_true = 1'b0; boff = '0;
    chk("addr_jump", 32'(addr), 32'h100);

    // redirect during the bubble is ignored
    jmp = 1'b1; jidx = 5'd7;
    expect_edge(1'b1, 9'h100, 10'h100, 16'd12, 1'b0, 1'b1); cycle("jump_in_bubble");
    jmp = 1'b0; jidx = '0;
    chk("addr_after_bubble", 32'(addr), 32'h101);

    // done together with jmp: halt wins
    done = 1'b1; jmp = 1'b1; jidx = 5'd4;
    expect_edge(1'b0, 9'h100, 10'h000, 16'd12, 1'b1, 1'b0); cycle("halt");
    done = 1'b0; jmp = 1'b0; jidx = '0;
    chk("addr_halt", 32'(addr), 32'h101);
    branch = 1'b1; cond_true = 1'b1; jmp = 1'b1; jidx = 5'd4;
    expect_edge(1'b0, 9'h100, 10'h000, 16'd12, 1'b1, 1'b0); cycle("halt_hold");
    branch = 1'b0; cond_true = 1'b0; jmp = 1'b0; jidx = '0;
    chk("addr_halt_hold", 32'(addr), 32'h101);

    // restart from HALT
    start = 1'b1;
    expect_edge(1'b0, 9'h100, 10'h000, 16'd0, 1'b0, 1'b0); cycle("restart");
    start = 1'b0;
    chk("addr_restart", 32'(addr), 0);
    expect_edge(1'b1, 9'h000, 10'h000, 16'd1, 1'b0, 1'b1); cycle("restart_seq");
    chk("addr_restart_seq", 32'(addr), 1);

    // reset asserted mid-bubble
    jmp = 1'b1; jidx = 5'd4;
    expect_edge(1'b0, 9'h000, 10'h000, 16'd1, 1'b0, 1'b0); cycle("jump_pre_reset");
    jmp = 1'b0; jidx = '0;
    chk("addr_pre_reset", 32'(addr), 32'h100);
    #2 rst = 1'b1;
    #1;
    chk("midrst.valid", 32'(valid), 0);
    chk("midrst.instr", 32'(instr), 0);
    chk("midrst.issued_pc", 32'(ipc), 0);
    chk("midrst.halted", 32'(halted), 0);
    chk("midrst.retired", 32'(ret), 0);
    chk("midrst.addr", 32'(addr), 0);
    @(posedge clk); #1;
    chk("rst_hold.valid", 32'(valid), 0);
    @(negedge clk);
    rst = 1'b0;

    // narrow instance: counter saturation and PC wrap
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("small.start_retired", 32'(ret_s), 0);
    chk("small.start_addr", 32'(addr_s), 0);
    for (int k = 0; k < 16; k++) begin
      @(posedge clk); #1;
      chk($sformatf("small.issued_pc[%0d]", k), 32'(ipc_s), 32'(k));
      chk($sformatf("small.instr[%0d]", k), 32'(instr_s), 32'(k));
      chk($sformatf("small.retired[%0d]", k), 32'(ret_s), (k < 3) ? 32'(k + 1) : 32'd3);
      chk($sformatf("small.addr[%0d]", k), 32'(addr_s), 32'((k + 1) % 16));
      $display("small k=%0d addr=%0h issued_pc=%0h retired=%0d", k, addr_s, ipc_s, ret_s);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Instruction-fetch front end that drives 9-bit instructions into the decode/control unit.
- Consumes the decoder's branch, jmp_ctrl and done_ctrl outputs.
- Owns the program counter, the jump-target table, run/halt sequencing and the retired-instruction counter.
- Sits between the combinational instruction ROM and the control unit.

Parameters:
- PC_W, 10, program counter / ROM address width.
- CNT_W, 16, retired-instruction counter width.
- JLUT_DEPTH, 32, jump-target table entries, indexed by instruction[4:0].

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  one-cycle pulse: begin execution at PC 0.
- imem_addr  out  PC_W  ROM address; equals pc.
- imem_data  in  9  combinational ROM data for imem_addr.
- instruction  out  9  registered instruction to the control unit.
- instr_valid  out  1  instruction is live (not a bubble).
- issued_pc  out  PC_W  address of the instruction currently on `instruction`.
- branch  in  1  branch-class instruction (from control unit).
- cond_true  in  1  branch condition met (from ALU flags).
- branch_offset  in  5  signed offset relative to issued_pc.
- jmp_ctrl  in  1  jump request.
- jmp_index  in  5  jump-table index.
- done_ctrl  in  1  halt request.
- halted  out  1  program finished.
- retired  out  CNT_W  count of valid instructions issued; saturating.

Behaviour:
- Reset values: pc=0, instruction=9'b0, instr_valid=0, issued_pc=0, halted=0, retired=0, state=IDLE.
- States: IDLE, RUN, HALT.
- IDLE:
  - Outputs hold.
  - start -> pc<=0, go to RUN.
  - Redirect and done inputs are ignored.
- RUN, every edge:
  - instruction<=imem_data.
  - issued_pc<=pc.
  - instr_valid<=1.
  - pc<=pc+1, wrapping modulo 2^PC_W.
  - retired increments for each valid issue, saturating at all-ones.
- Redirect priority, highest first: done_ctrl > jmp_ctrl > (branch & cond_true) > sequential.
- done_ctrl in RUN:
  - Go to HALT.
  - instr_valid<=0.
  - halted<=1.
  - pc frozen.
- jmp_ctrl:
  - pc<=jlut[jmp_index].
  - Next edge issues a bubble: instr_valid=0, instruction=0, retired unchanged.
- branch & cond_true:
  - pc<=issued_pc + sign_extend(branch_offset), modulo 2^PC_W.
  - One-cycle bubble, as for jmp_ctrl.
- branch & !cond_true: sequential fetch, no bubble.
- Redirect inputs apply only while instr_valid=1. They are ignored during a bubble.
- HALT:
  - halted stays 1.
  - All inputs ignored except start.
  - start -> halted<=0, pc<=0, retired<=0, go to RUN.
- start asserted while in RUN: ignored.
- reset asserted mid-RUN or mid-bubble: immediate return to reset values; no partial retire.
- Jump table:
  - Constant, loaded from the shared package.
  - Entries at or beyond JLUT_DEPTH read 0.
- Latency:
  - ROM address to instruction: 1 cycle.
  - Redirect to first target instruction: 2 edges (one bubble).

Decomposition:
- Shared package, ctrl_pkg:
  - 4-bit opcode constants.
  - 3-bit special-op constants.
  - Fetch state encoding (IDLE=2'd0, RUN=2'd1, HALT=2'd2).
  - Jump-table initial contents.
- The control unit imports ctrl_pkg as well.
- One sub-module, jump_lut: combinational 5-bit index -> PC_W target, with out-of-range entries reading 0.

Test Plan:
- Reset, then start; ROM holds 0x000..0x003 at addresses 0..3.
  -> imem_addr steps 0,1,2,3.
  -> instruction tracks one cycle later with instr_valid=1.
  -> retired=3 after the third valid issue.
- Branch taken: at issued_pc=5, branch=1, cond_true=1, branch_offset=-3.
  -> next pc=2; one bubble (instr_valid=0); then issued_pc=2.
- Branch not taken: at issued_pc=5, branch=1, cond_true=0.
  -> issued_pc=6 next, no bubble.
- Jump with jlut[4]=0x100 and jmp_index=4; same cycle assert branch & cond_true.
  -> jump wins; issued_pc=0x100 after one bubble.
- Halt: done_ctrl=1 together with jmp_ctrl=1.
  -> HALT, halted=1, pc frozen, retired frozen.
  -> start -> halted=0, pc=0, retired=0.
- Wrap and saturation:
  - PC_W=4 at pc=15, sequential -> pc=0.
  - CNT_W=2: fifth retire keeps retired=3.
  - reset mid-bubble -> all outputs at reset values on the same edge.
